// File: rtl/fast_uint_encoder_if.sv
// rtl/fast_uint_encoder_if.sv - field input and byte output stream bundle for the FAST uint encoder
interface fast_uint_encoder_if #(
  parameter int IN_WIDTH = 64
);
  logic                in_valid;
  logic                in_ready;
  logic [IN_WIDTH-1:0] in_value;
  logic                in_nullable;
  logic                in_is_null;
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          out_byte;
  logic                out_last;
  logic                busy;

  // encoder side
  modport slave (
    input  in_valid, in_value, in_nullable, in_is_null, out_ready,
    output in_ready, out_valid, out_byte, out_last, busy
  );

  // producer of fields and consumer of bytes
  modport master (
    output in_valid, in_value, in_nullable, in_is_null, out_ready,
    input  in_ready, out_valid, out_byte, out_last, busy
  );
endinterface

// File: rtl/fast_uint_encoder.sv
// rtl/fast_uint_encoder.sv - FAST stop-bit uint encoder with nullable adjustment
module fast_uint_encoder #(
  parameter int IN_WIDTH  = 64,
  parameter int MAX_BYTES = 10
) (
  input logic                clk,
  input logic                rst,
  fast_uint_encoder_if.slave bus
);
  localparam int SR_W = MAX_BYTES * 7;
  localparam int AW   = IN_WIDTH + 1;
  localparam int CW   = $clog2(MAX_BYTES + 1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t          state_q, state_d;
  logic [SR_W-1:0] sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [AW-1:0]   adj;
  logic [SR_W-1:0] adj_ext;
  logic [SR_W-1:0] adj_aligned;
  logic [CW-1:0]   len;
  logic            last;
  logic            xfer;
  logic            accept;

  // nullable adjustment; the extra top bit keeps the carry of all-ones + 1
  always_comb begin
    adj = {1'b0, bus.in_value};
    if (bus.in_nullable) begin
      if (bus.in_is_null) begin
        adj = '0;
      end else begin
        adj = {1'b0, bus.in_value} + AW'(1);
      end
    end
  end

  // group count and left alignment so the first byte comes from the top of the register
  always_comb begin
    adj_ext = SR_W'(adj);
    len     = CW'(1);
    for (int g = 0; g < MAX_BYTES; g++) begin
      if (adj_ext[g*7 +: 7] != 7'd0) begin
        len = CW'(g + 1);
      end
    end
    adj_aligned = adj_ext << (7 * (MAX_BYTES - int'(len)));
  end

  assign last          = (cnt_q == CW'(1));
  assign bus.out_valid = (state_q == EMIT);
  assign bus.busy      = (state_q == EMIT);
  assign bus.out_byte  = (state_q == EMIT) ? {last, sr_q[SR_W-1 -: 7]} : 8'h00;
  assign bus.out_last  = bus.out_byte[7];
  assign xfer          = bus.out_valid && bus.out_ready;
  // a new field may load on the same edge the previous field's last byte leaves
  assign bus.in_ready  = (state_q == IDLE) || (xfer && last);
  assign accept        = bus.in_valid && bus.in_ready;

  // state, shift register and byte counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  // load on accept, shift out one group per transferred byte, hold under backpressure
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EMIT;
          sr_d    = adj_aligned;
          cnt_d   = len;
        end
      end
      EMIT: begin
        if (xfer) begin
          if (last) begin
            if (accept) begin
              sr_d  = adj_aligned;
              cnt_d = len;
            end else begin
              state_d = IDLE;
              sr_d    = '0;
              cnt_d   = '0;
            end
          end else begin
            sr_d  = sr_q << 7;
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        sr_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_fast_uint_encoder.sv
// tb/tb_fast_uint_encoder.sv - directed self-checking bench for fast_uint_encoder
module tb_fast_uint_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   assert_count = 0;
  int   fail_count = 0;

  logic [7:0] byte_q[$];
  logic       last_q[$];
  int         bcyc_q[$];
  int         acc_q[$];

  fast_uint_encoder_if #(.IN_WIDTH(64)) bus ();

  fast_uint_encoder #(.IN_WIDTH(64), .MAX_BYTES(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // record transferred bytes and accepted fields just before the edge that consumes them
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        byte_q.push_back(bus.out_byte);
        last_q.push_back(bus.out_last);
        bcyc_q.push_back(cyc);
      end
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // caller must be at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [63:0] v, input logic n, input logic z);
    logic got;
    bus.in_valid    = 1'b1;
    bus.in_value    = v;
    bus.in_nullable = n;
    bus.in_is_null  = z;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!got) check_eq("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_bytes(input int n);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (byte_q.size() >= n) break;
    end
    if (i == 200) check_eq("wait_timeout", 64'(byte_q.size()), 64'(n));
  endtask

  task automatic check_byte(input string tag, input int idx, input logic [7:0] eb, input logic el);
    if (idx < byte_q.size()) begin
      check_eq({tag, "_byte"}, 64'(byte_q[idx]), 64'(eb));
      check_eq({tag, "_last"}, 64'(last_q[idx]), 64'(el));
    end else begin
      check_eq({tag, "_missing"}, 64'hdead, 64'(eb));
    end
  endtask

  initial begin
    int n0;
    int a0;
    bus.in_valid    = 1'b0;
    bus.in_value    = '0;
    bus.in_nullable = 1'b0;
    bus.in_is_null  = 1'b0;
    bus.out_ready   = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_out_byte", 64'(bus.out_byte), 64'd0);
    check_eq("rst_out_last", 64'(bus.out_last), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    sync();
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    sync();

    // non-nullable zero, latency one cycle
    n0 = byte_q.size();
    send(64'd0, 1'b0, 1'b0);
    wait_bytes(n0 + 1);
    check_byte("zero", n0, 8'h80, 1'b1);
    if (byte_q.size() > n0 && acc_q.size() > 0)
      check_eq("zero_latency", 64'(bcyc_q[n0] - acc_q[acc_q.size()-1]), 64'd1);
    else
      check_eq("zero_latency_missing", 64'd0, 64'd1);

    // NULL then nullable zero, back-to-back
    sync();
    n0 = byte_q.size();
    a0 = acc_q.size();
    send(64'd0, 1'b1, 1'b1);
    send(64'd0, 1'b1, 1'b0);
    wait_bytes(n0 + 2);
    check_byte("null", n0, 8'h80, 1'b1);
    check_byte("nzero", n0 + 1, 8'h81, 1'b1);
    if (byte_q.size() >= n0 + 2 && acc_q.size() >= a0 + 2) begin
      check_eq("b2b_gap", 64'(bcyc_q[n0+1] - bcyc_q[n0]), 64'd1);
      check_eq("b2b_accept", 64'(acc_q[a0+1]), 64'(bcyc_q[n0]));
    end else begin
      check_eq("b2b_missing", 64'd0, 64'd1);
    end

    // 300 -> 0x02 0xAC
    sync();
    n0 = byte_q.size();
    send(64'd300, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("v300_busy", 64'(bus.busy), 64'd1);
    wait_bytes(n0 + 2);
    check_byte("v300_0", n0, 8'h02, 1'b0);
    check_byte("v300_1", n0 + 1, 8'hAC, 1'b1);

    // nullable all-ones -> 2^64, ten bytes
    sync();
    n0 = byte_q.size();
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    wait_bytes(n0 + 10);
    check_byte("ones_0", n0, 8'h02, 1'b0);
    for (int i = 1; i < 9; i++) check_byte($sformatf("ones_%0d", i), n0 + i, 8'h00, 1'b0);
    check_byte("ones_9", n0 + 9, 8'h80, 1'b1);

    // backpressure on the first byte of 300
    sync();
    n0 = byte_q.size();
    bus.out_ready = 1'b0;
    send(64'd300, 1'b0, 1'b0);
    a0 = acc_q.size();
    bus.in_valid = 1'b1;
    bus.in_value = 64'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("bp_valid_%0d", i), 64'(bus.out_valid), 64'd1);
      check_eq($sformatf("bp_byte_%0d", i), 64'(bus.out_byte), 64'h02);
      check_eq($sformatf("bp_last_%0d", i), 64'(bus.out_last), 64'd0);
      check_eq($sformatf("bp_in_ready_%0d", i), 64'(bus.in_ready), 64'd0);
    end
    sync();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check_eq("bp_no_accept", 64'(acc_q.size()), 64'(a0));
    wait_bytes(n0 + 2);
    check_byte("bp_0", n0, 8'h02, 1'b0);
    check_byte("bp_1", n0 + 1, 8'hAC, 1'b1);

    // reset after byte 3 of a ten-byte field
    sync();
    n0 = byte_q.size();
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    wait_bytes(n0 + 3);
    sync();
    rst = 1'b1;
    sync();
    check_eq("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b0;
    sync();
    send(64'd127, 1'b0, 1'b0);
    wait_bytes(n0 + 4);
    check_byte("v127", n0 + 3, 8'hFF, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("midrst_count", 64'(byte_q.size() - n0), 64'd4);
    check_eq("final_idle", 64'(bus.busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule

// File: doc/fast_uint_encoder.md
Name: fast_uint_encoder

Overview:
Serialises one unsigned integer per transaction into a FAST stop-bit-encoded byte stream, most-significant 7-bit group first, with bit[7] set only on the final byte. It implements nullable adjustment: NULL is encoded as 0x80, and any non-null nullable value is sent as value+1. It is the transmit-side counterpart of the FAST uint field decoder and feeds the FAST message assembler through a byte-wide valid/ready stream.

Parameters:
IN_WIDTH, 64, width of the unsigned input value.
MAX_BYTES, 10, maximum encoded bytes per field; the design requires MAX_BYTES*7 >= IN_WIDTH+1.

Ports:
clk  input  1  single clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  an input field is presented.
in_ready  output  1  the encoder can accept a field this cycle.
in_value  input  IN_WIDTH  unsigned value to encode.
in_nullable  input  1  the field is nullable.
in_is_null  input  1  encode NULL; ignored when in_nullable=0.
out_valid  output  1  out_byte is valid.
out_ready  input  1  downstream accepts out_byte.
out_byte  output  8  encoded byte; bit[7] is the stop bit.
out_last  output  1  final byte of the field; equals out_byte[7].
busy  output  1  a field is being emitted (state EMIT).

Behaviour:
- Reset, sampled on the clk edge while rst=1:
  - state=IDLE; out_valid=0; out_byte=0; out_last=0; busy=0; internal shift register and counter cleared.
  - in_ready=1 in the first cycle after rst deasserts.
  - Reset mid-field abandons the field immediately; no further bytes are emitted.
- Accept: a field is accepted when in_valid && in_ready.
  - in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
  - This gives zero-bubble back-to-back fields.
- Adjustment, computed on IN_WIDTH+1 bits:
  - in_nullable && in_is_null: adj = 0.
  - in_nullable && !in_is_null: adj = in_value+1. The carry is kept, so all-ones gives 2^IN_WIDTH.
  - !in_nullable: adj = in_value.
- Length:
  - len = number of 7-bit groups needed for adj, minimum 1.
  - len = max(1, ceil(msb_index(adj)+1 / 7)).
  - adj=0 gives len=1.
- Load: on the accept edge:
  - adj is loaded, zero-extended to MAX_BYTES*7 bits and left-aligned so the most significant non-empty group is at the top.
  - byte counter is set to len.
  - state moves to EMIT and out_valid goes to 1 on the next cycle.
  - Latency is 1 cycle from accept to the first out_valid.
- EMIT:
  - out_byte = {last, group}.
  - last=1 when the counter equals 1.
  - On out_valid && out_ready: shift the register left by 7 and decrement the counter.
  - When the last byte is transferred:
    - with a new field accepted in the same cycle: load it and stay in EMIT, out_valid stays 1;
    - otherwise: move to IDLE, out_valid=0, out_byte=0, out_last=0.
- Backpressure: while out_valid && !out_ready, out_byte, out_last and internal state are held stable.
- Input handling:
  - in_value, in_nullable and in_is_null are sampled only on accept, so later changes have no effect.
  - Inputs presented while in_ready=0 are not consumed.
- Throughput: len+0 cycles per field when out_ready is held high.

Test Plan:
- Reset, then non-nullable in_value=0 -> single byte 0x80 with out_last=1, first out_valid 1 cycle after accept.
- in_nullable=1, in_is_null=1 -> 0x80. Then in_nullable=1, in_value=0 -> 0x81. These are sent back-to-back with no idle cycle between the fields.
- Non-nullable in_value=300 -> 0x02 then 0xAC. out_last is 0 then 1.
- in_nullable=1, in_value=0xFFFF_FFFF_FFFF_FFFF -> 10 bytes: 0x02, eight 0x00, 0x80. Confirms the carry into bit 64.
- in_value=300 with out_ready=0 for 3 cycles on byte 1 -> 0x02 held stable, in_ready=0 throughout. Stream resumes as 0x02, 0xAC.
- rst=1 after byte 3 of a 10-byte field -> next cycle out_valid=0, in_ready=1. The following field (non-nullable 127 -> 0xFF) encodes correctly.
